// File: rtl/viterbi_pkg.sv
// ---------------------------------------------------------------------------
// viterbi_pkg
// Shared constants for the Viterbi decoder blocks. The survivor RAM picks up
// its default geometry from here so every instance agrees on row count,
// row width and address width unless explicitly overridden.
//   SURV_NROWS     : number of survivor rows (power of two)
//   SURV_NBITS     : bits per survivor row
//   SURV_ADDR_BITS : log2(SURV_NROWS)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package viterbi_pkg;

    localparam int SURV_NROWS     = 64;
    localparam int SURV_NBITS     = 4;
    localparam int SURV_ADDR_BITS = 6;

endpackage

// File: rtl/survivor_row.sv
// ---------------------------------------------------------------------------
// survivor_row
// One storage row of the survivor RAM: an NBITS register loaded when its
// write enable is high, cleared asynchronously by reset.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low clear
//   i_we   : load enable for this row
//   i_d    : data to store
//   o_q    : current row contents
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module survivor_row #(
    parameter int NBITS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_we,
    input  logic [NBITS-1:0] i_d,
    output logic [NBITS-1:0] o_q
);

    logic [NBITS-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_we) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/survivor_ram.sv
// ---------------------------------------------------------------------------
// survivor_ram
// Circular survivor-path store. Writes append at wr_ptr and wrap, overwriting
// the oldest row. Reads are either absolute (rel=0, cr = row) or relative to
// the newest row (rel=1, cr = how many rows back). Read data is registered
// with one cycle of latency; reads of rows that hold no data return zero and
// raise o_err.
// Ports:
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   cs      : chip select, gates we and re
//   we      : append i at wr_ptr
//   re      : read request
//   rel     : 0 = absolute address, 1 = offset back from newest row
//   cr      : address (rel=0) or offset (rel=1)
//   i       : write data
//   o       : registered read data (held when no read)
//   o_valid : o carries the result of a read issued on the previous edge
//   o_err   : last read addressed an unwritten row
//   full    : every row has been written since reset
//   wr_ptr  : next row to be written
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module survivor_ram
    import viterbi_pkg::*;
#(
    parameter int NROWS     = SURV_NROWS,
    parameter int NBITS     = SURV_NBITS,
    parameter int ADDR_BITS = SURV_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cs,
    input  logic                 we,
    input  logic                 re,
    input  logic                 rel,
    input  logic [ADDR_BITS-1:0] cr,
    input  logic [NBITS-1:0]     i,
    output logic [NBITS-1:0]     o,
    output logic                 o_valid,
    output logic                 o_err,
    output logic                 full,
    output logic [ADDR_BITS-1:0] wr_ptr
);

    localparam logic [ADDR_BITS:0]   FULL_CNT = (ADDR_BITS+1)'(NROWS);
    localparam logic [ADDR_BITS:0]   CNT_ONE  = (ADDR_BITS+1)'(1);
    localparam logic [ADDR_BITS-1:0] PTR_ONE  = ADDR_BITS'(1);

    logic [NBITS-1:0]     w_row_q [NROWS];
    logic [NROWS-1:0]     r_written;
    logic [ADDR_BITS:0]   r_count;
    logic [ADDR_BITS-1:0] r_wr_ptr;
    logic [NBITS-1:0]     r_o;
    logic                 r_valid;
    logic                 r_err;

    logic                 w_wr;
    logic                 w_rd;
    logic [ADDR_BITS-1:0] w_rd_addr;
    logic                 w_rd_miss;

    assign w_wr = cs & we;
    assign w_rd = cs & re;

    // Relative reads are taken from the pointer as it stands before any write
    // on this same edge; subtraction wraps naturally at ADDR_BITS.
    assign w_rd_addr = rel ? (r_wr_ptr - PTR_ONE - cr) : cr;

    // A relative offset is valid only if that many rows have been written;
    // an absolute address needs its row's written flag.
    assign w_rd_miss = rel ? ({1'b0, cr} >= r_count) : ~r_written[w_rd_addr];

    for (genvar g = 0; g < NROWS; g++) begin : g_row
        survivor_row #(
            .NBITS (NBITS)
        ) u_row (
            .clk   (clk),
            .rst_n (rst_n),
            .i_we  (w_wr && (r_wr_ptr == ADDR_BITS'(g))),
            .i_d   (i),
            .o_q   (w_row_q[g])
        );
    end

    // Write pointer, fill count (saturating) and per-row written flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_written <= '0;
        end else if (w_wr) begin
            r_wr_ptr            <= r_wr_ptr + PTR_ONE;
            r_written[r_wr_ptr] <= 1'b1;
            if (r_count != FULL_CNT) begin
                r_count <= r_count + CNT_ONE;
            end
        end
    end

    // Read port. Rows are sampled before this edge's write lands, which gives
    // read-before-write on a same-address collision. o and o_err only move on
    // a read; o_valid tracks whether a read was issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_o     <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= w_rd;
            if (w_rd) begin
                r_o   <= w_rd_miss ? '0 : w_row_q[w_rd_addr];
                r_err <= w_rd_miss;
            end
        end
    end

    assign o       = r_o;
    assign o_valid = r_valid;
    assign o_err   = r_err;
    assign full    = (r_count == FULL_CNT);
    assign wr_ptr  = r_wr_ptr;

endmodule

// File: tb/tb_survivor_ram.sv
`timescale 1ns/1ps
module tb_survivor_ram;

    localparam int NR = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs = 1'b0, we = 1'b0, re = 1'b0, rel = 1'b0;
    logic [5:0] cr = '0;
    logic [3:0] i = '0;
    logic [3:0] o;
    logic       o_valid, o_err, full;
    logic [5:0] wr_ptr;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: a plain circular list of written values.
    int         m_mem [NR];
    bit         m_wr  [NR];
    int         m_cnt;
    int         m_wp;
    logic [3:0] e_o;
    logic       e_v, e_err;

    survivor_ram dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cs      (cs),
        .we      (we),
        .re      (re),
        .rel     (rel),
        .cr      (cr),
        .i       (i),
        .o       (o),
        .o_valid (o_valid),
        .o_err   (o_err),
        .full    (full),
        .wr_ptr  (wr_ptr)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int k = 0; k < NR; k++) begin
            m_mem[k] = 0;
            m_wr[k]  = 0;
        end
        m_cnt = 0;
        m_wp  = 0;
        e_o   = '0;
        e_v   = 1'b0;
        e_err = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cs = 0; we = 0; re = 0; rel = 0; cr = '0; i = '0;
        model_clear();
        #3;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock of stimulus; the model predicts what the outputs show after it.
    task automatic step(input bit c, input bit w, input bit r, input bit rl,
                        input int a, input int d);
        int  addr;
        bit  miss;
        @(negedge clk);
        cs = c; we = w; re = r; rel = rl;
        cr = 6'(a);
        i  = 4'(d);
        @(posedge clk);
        if (c && r) begin
            if (rl) begin
                addr = (m_wp - 1 - a + 2 * NR) % NR;
                miss = (a >= m_cnt);
            end else begin
                addr = a;
                miss = !m_wr[a];
            end
            e_v   = 1'b1;
            e_err = miss;
            e_o   = miss ? 4'h0 : 4'(m_mem[addr]);
        end else begin
            e_v = 1'b0;
        end
        if (c && w) begin
            m_mem[m_wp] = d % 16;
            m_wr[m_wp]  = 1;
            m_wp        = (m_wp + 1) % NR;
            if (m_cnt < NR) m_cnt++;
        end
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({o, o_valid, o_err, full, wr_ptr} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_state: got o=%h v=%b e=%b full=%b wp=%0d, need all zero",
                     o, o_valid, o_err, full, wr_ptr);
        end
        step(1, 0, 1, 0, 5, 0);
        n_checks++;
        if (o !== 4'h0 || o_valid !== 1'b1 || o_err !== 1'b1) begin
            n_fail++;
            $display("FAIL unwritten_read: got o=%h v=%b e=%b, need o=0 v=1 e=1", o, o_valid, o_err);
        end
        n_checks++;
        if (full !== 1'b0 || wr_ptr !== 6'd0) begin
            n_fail++;
            $display("FAIL unwritten_read_state: got full=%b wp=%0d, need 0 0", full, wr_ptr);
        end
    endtask

    task automatic test_relative();
        apply_reset();
        step(1, 1, 0, 0, 0, 'hA);
        step(1, 1, 0, 0, 0, 'hB);
        step(1, 1, 0, 0, 0, 'hC);
        n_checks++;
        if (wr_ptr !== 6'd3) begin
            n_fail++;
            $display("FAIL rel_wr_ptr: got %0d need 3", wr_ptr);
        end
        step(1, 0, 1, 1, 0, 0);
        n_checks++;
        if (o !== 4'hC || o_valid !== 1'b1 || o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rel_cr0: got o=%h v=%b e=%b need C 1 0", o, o_valid, o_err);
        end
        step(1, 0, 1, 1, 2, 0);
        n_checks++;
        if (o !== 4'hA || o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rel_cr2: got o=%h e=%b need A 0", o, o_err);
        end
        step(1, 0, 1, 1, 3, 0);
        n_checks++;
        if (o !== 4'h0 || o_err !== 1'b1 || o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rel_cr3: got o=%h v=%b e=%b need 0 1 1", o, o_valid, o_err);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int k = 0; k < 65; k++) step(1, 1, 0, 0, 0, k % 16);
        n_checks++;
        if (full !== 1'b1 || wr_ptr !== 6'd1) begin
            n_fail++;
            $display("FAIL wrap_state: got full=%b wp=%0d need 1 1", full, wr_ptr);
        end
        step(1, 0, 1, 0, 0, 0);
        n_checks++;
        if (o !== 4'h0 || o_err !== 1'b0 || o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_abs0: got o=%h v=%b e=%b need 0 1 0", o, o_valid, o_err);
        end
        step(1, 0, 1, 1, 63, 0);
        n_checks++;
        if (o !== 4'h1 || o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_rel63: got o=%h e=%b need 1 0", o, o_err);
        end
    endtask

    task automatic test_read_before_write();
        apply_reset();
        for (int k = 0; k < 64; k++) step(1, 1, 0, 0, 0, (k == 7) ? 3 : (k * 5) % 16);
        for (int k = 0; k < 7; k++) step(1, 1, 0, 0, 0, k + 1);
        n_checks++;
        if (wr_ptr !== 6'd7) begin
            n_fail++;
            $display("FAIL rbw_ptr: got %0d need 7", wr_ptr);
        end
        step(1, 1, 1, 0, 7, 9);
        n_checks++;
        if (o !== 4'h3 || o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rbw_old: got o=%h e=%b need 3 0", o, o_err);
        end
        step(1, 0, 1, 0, 7, 0);
        n_checks++;
        if (o !== 4'h9) begin
            n_fail++;
            $display("FAIL rbw_new: got o=%h need 9", o);
        end
    endtask

    task automatic test_cs_gate();
        apply_reset();
        for (int k = 0; k < 5; k++) step(1, 1, 0, 0, 0, k + 4);
        step(1, 0, 1, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 1, k % 2, $urandom_range(0, 63), $urandom_range(0, 15));
            n_checks++;
            if (o_valid !== 1'b0 || wr_ptr !== 6'd5) begin
                n_fail++;
                $display("FAIL cs_gate: got v=%b wp=%0d need 0 5", o_valid, wr_ptr);
            end
        end
        step(1, 0, 1, 1, 5, 0);
        n_checks++;
        if (o_err !== 1'b1 || o !== 4'h0) begin
            n_fail++;
            $display("FAIL cs_gate_count5: got o=%h e=%b need 0 1", o, o_err);
        end
        step(1, 0, 1, 1, 4, 0);
        n_checks++;
        if (o !== e_o || o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL cs_gate_count4: got o=%h e=%b need %h 0", o, o_err, e_o);
        end
    endtask

    task automatic test_hold();
        logic [3:0] prev;
        step(1, 0, 1, 1, 1, 0);
        prev = o;
        n_checks++;
        if (o !== e_o) begin
            n_fail++;
            $display("FAIL hold_setup: got o=%h need %h", o, e_o);
        end
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        n_checks++;
        if (o !== prev || o_valid !== 1'b0 || o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL hold: got o=%h v=%b e=%b need %h 0 0", o, o_valid, o_err, prev);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            step(($urandom % 4) != 0, $urandom % 2, $urandom % 2, $urandom % 2,
                 $urandom_range(0, 63), $urandom_range(0, 15));
            n_checks++;
            if (o_valid !== e_v) begin
                n_fail++;
                $display("FAIL rand_valid cyc%0d: got %b need %b", n, o_valid, e_v);
            end
            n_checks++;
            if (o !== e_o || o_err !== e_err) begin
                n_fail++;
                $display("FAIL rand_data cyc%0d: got o=%h e=%b need %h %b", n, o, o_err, e_o, e_err);
            end
            n_checks++;
            if (wr_ptr !== 6'(m_wp) || full !== (m_cnt == NR)) begin
                n_fail++;
                $display("FAIL rand_ptr cyc%0d: got wp=%0d full=%b need %0d %b",
                         n, wr_ptr, full, m_wp, (m_cnt == NR));
            end
        end
    endtask

    task automatic test_reset_abort();
        step(1, 1, 0, 0, 0, 5);
        step(1, 0, 1, 1, 0, 0);
        @(negedge clk);
        cs = 1; we = 0; re = 1; rel = 0; cr = '0;
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if ({o, o_valid, o_err, full, wr_ptr} !== 13'h0) begin
            n_fail++;
            $display("FAIL abort_async: got o=%h v=%b e=%b full=%b wp=%0d need all zero",
                     o, o_valid, o_err, full, wr_ptr);
        end
        @(negedge clk);
        cs = 0; re = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 0, 0, 0, 6);
        n_checks++;
        if (o_valid !== 1'b0 || o !== 4'h0 || wr_ptr !== 6'd1) begin
            n_fail++;
            $display("FAIL abort_release: got v=%b o=%h wp=%0d need 0 0 1", o_valid, o, wr_ptr);
        end
        step(1, 0, 1, 0, 0, 0);
        n_checks++;
        if (o !== 4'h6 || o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_newdata: got o=%h e=%b need 6 0", o, o_err);
        end
        step(1, 0, 1, 0, 1, 0);
        n_checks++;
        if (o !== 4'h0 || o_err !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_cleared: got o=%h e=%b need 0 1", o, o_err);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_relative();
        test_wrap();
        test_read_before_write();
        test_cs_gate();
        test_hold();
        test_random();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/survivor_ram.md
SURVIVOR_RAM -- requirements
Module: survivor_ram

Interface
REQ-001 SHALL have parameter NROWS, default 64, number of storage rows (power of two, 4..1024).
REQ-002 SHALL have parameter NBITS, default 4, row width in bits (1..32).
REQ-003 SHALL have parameter ADDR_BITS, default 6, equal to log2(NROWS).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port cs  input  1  chip select; gates all reads and writes.
REQ-007 SHALL have port we  input  1  write strobe; append i at write pointer.
REQ-008 SHALL have port re  input  1  read strobe.
REQ-009 SHALL have port rel  input  1  read mode: 0 = absolute address, 1 = offset back from newest row.
REQ-010 SHALL have port cr  input  ADDR_BITS  read address (rel=0) or offset (rel=1).
REQ-011 SHALL have port i  input  NBITS  write data.
REQ-012 SHALL have port o  output  NBITS  registered read data.
REQ-013 SHALL have port o_valid  output  1  o holds a valid result this cycle.
REQ-014 SHALL have port o_err  output  1  last read addressed an unwritten row.
REQ-015 SHALL have port full  output  1  all NROWS rows written since reset.
REQ-016 SHALL have port wr_ptr  output  ADDR_BITS  next row to be written.

Function
REQ-017 Write: cs&we at edge stores i into row wr_ptr, then wr_ptr increments mod NROWS (wraps NROWS-1 -> 0, overwriting oldest).
REQ-018 Fill count SHALL increment on each write, saturating at NROWS; full = (count == NROWS).
REQ-019 Read: cs&re at edge N SHALL produce o, o_valid=1 at edge N+1 (1-cycle latency); o_valid=0 for a cycle with no read.
REQ-020 Effective address: rel=0 -> cr; rel=1 -> (wr_ptr - 1 - cr) mod NROWS, using wr_ptr before any same-cycle write.
REQ-021 Unwritten row: rel=0 and row never written, or rel=1 and cr >= count -> o=0, o_err=1, o_valid=1.
REQ-022 o_err SHALL be 0 on every valid read hitting a written row; o_err updates only on reads.
REQ-023 Simultaneous write and read of same effective address SHALL return the old row contents (read-before-write).
REQ-024 o SHALL hold its last value when no read occurs; only o_valid drops.
REQ-025 we/re with cs=0 SHALL be ignored: no state change, o_valid=0 next cycle.
REQ-026 Per-row written flags SHALL track validity for rel=0 reads; all set once full.

Reset
REQ-027 rst_n low SHALL immediately clear all rows to 0, written flags, count, wr_ptr=0, o=0, o_valid=0, o_err=0, full=0.
REQ-028 Reset asserted mid-operation SHALL abort any pending read (no o_valid after release); first cycle after release accepts new commands.

Structure
REQ-029 Shared package viterbi_pkg SHALL hold default constants SURV_NROWS=64, SURV_NBITS=4, SURV_ADDR_BITS=6.
REQ-030 One sub-module survivor_row SHALL implement one NBITS row register with write enable and async clear; instantiated NROWS times.
REQ-031 No tristate drivers; o is a plain registered output.

Verification
REQ-032 Reset, then read rel=0 cr=5 -> next cycle o=0, o_valid=1, o_err=1; full=0, wr_ptr=0.
REQ-033 Write 0xA,0xB,0xC -> wr_ptr=3; read rel=1 cr=0 -> o=0xC; rel=1 cr=2 -> o=0xA; rel=1 cr=3 -> o_err=1.
REQ-034 Write 65 rows (data = index mod 16) -> full=1, wr_ptr=1; rel=0 cr=0 -> o=0x0 (row 64 value), rel=1 cr=63 -> o=0x1.
REQ-035 Row 7 holds 0x3; same cycle write 0x9 at row 7 and read rel=0 cr=7 -> o=0x3; following read -> 0x9.
REQ-036 cs=0 with we=1,re=1 for 4 cycles -> wr_ptr, count unchanged, o_valid=0.
REQ-037 Issue read, assert rst_n low before next edge -> o_valid=0 and all outputs zero after release.
